// File: rtl/key_poll_master.sv
// Avalon-MM master that polls a 4-bit KEY PIO, debounces the keys and queues
// one {pressed, index} event per accepted edge in a small first-word-fall-through FIFO.
module key_poll_master #(
  parameter int POLL_CYCLES      = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter bit KEY_ACTIVE_LOW   = 1'b1,
  parameter int RD_TIMEOUT       = 15,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [3:0]  key_state,
  output logic [2:0]  evt_data,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic        overflow,
  output logic        rd_error,
  input  logic        err_clr
);

  localparam int TW = $clog2(POLL_CYCLES);
  localparam int WW = $clog2(RD_TIMEOUT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_PROC,
    ST_EMIT
  } state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       pollTimer_q, pollTimer_d;
  logic [WW-1:0]       waitCnt_q, waitCnt_d;
  logic [3:0]          sample_q, sample_d;
  logic [3:0]          prev_q, prev_d;
  logic [3:0][3:0]     cnt_q, cnt_d;
  logic [3:0]          keyState_q, keyState_d;
  logic [3:0]          pend_q, pend_d;
  logic [2:0]          fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0]       wrPtr_q, rdPtr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, rdError_q;

  logic                pollTick;
  logic                push, pop, full, pushAccept, overflowSet, rdErrSet;
  logic [2:0]          pushData;
  logic [1:0]          lowIdx;
  logic [3:0]          cntInc;
  logic                unusedReaddata;

  assign unusedReaddata = ^avm_readdata[31:4];

  assign pollTick    = (pollTimer_q == '0);
  assign pollTimer_d = pollTick ? TW'(POLL_CYCLES - 1) : pollTimer_q - 1'b1;

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    sample_d   = sample_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    keyState_d = keyState_q;
    pend_d     = pend_q;
    avm_read   = 1'b0;
    push       = 1'b0;
    pushData   = 3'b000;
    rdErrSet   = 1'b0;
    lowIdx     = 2'd0;
    cntInc     = 4'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) lowIdx = 2'(i);
    end

    case (state_q)
      ST_IDLE: begin
        if (pollTick) state_d = ST_REQ;
      end
      ST_REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          state_d   = ST_WAIT;
          waitCnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (avm_readdatavalid) begin
          sample_d = KEY_ACTIVE_LOW ? ~avm_readdata[3:0] : avm_readdata[3:0];
          state_d  = ST_PROC;
        end else if (waitCnt_q == WW'(RD_TIMEOUT - 1)) begin
          waitCnt_d = WW'(RD_TIMEOUT);
          rdErrSet  = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      ST_PROC: begin
        pend_d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
          if (sample_q[i] != prev_q[i])  cntInc = 4'd1;
          else if (cnt_q[i] == 4'd15)    cntInc = 4'd15;
          else                           cntInc = cnt_q[i] + 4'd1;
          if ((sample_q[i] != keyState_q[i]) && (cntInc >= 4'(DEBOUNCE_SAMPLES))) begin
            keyState_d[i] = sample_q[i];
            pend_d[i]     = 1'b1;
            cnt_d[i]      = 4'd0;
          end else begin
            cnt_d[i] = cntInc;
          end
        end
        prev_d  = sample_q;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (pend_q != 4'b0000) begin
          push     = 1'b1;
          pushData = {keyState_q[lowIdx], lowIdx};
        end
        // Clearing the lowest set bit lets us leave on the same edge as the last push.
        pend_d = pend_q & (pend_q - 4'd1);
        if (pend_d == 4'b0000) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign pop         = evt_valid && evt_ready;
  assign pushAccept  = push && (!full || pop);
  assign overflowSet = push && full && !pop;

  always_comb begin
    count_d = count_q;
    if (pushAccept && !pop)      count_d = count_q + 1'b1;
    else if (!pushAccept && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pollTimer_q <= TW'(POLL_CYCLES - 1);
      waitCnt_q   <= '0;
      sample_q    <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      keyState_q  <= '0;
      pend_q      <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      rdError_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifoMem_q[i] <= 3'b000;
    end else begin
      state_q     <= state_d;
      pollTimer_q <= pollTimer_d;
      waitCnt_q   <= waitCnt_d;
      sample_q    <= sample_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      keyState_q  <= keyState_d;
      pend_q      <= pend_d;
      count_q     <= count_d;
      if (pushAccept) begin
        fifoMem_q[wrPtr_q] <= pushData;
        wrPtr_q            <= wrPtr_q + 1'b1;
      end
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
      // A set in the same cycle as err_clr keeps the flag raised.
      overflow_q <= overflowSet | (overflow_q & ~err_clr);
      rdError_q  <= rdErrSet | (rdError_q & ~err_clr);
    end
  end

  assign avm_address = 2'b00;
  assign key_state   = keyState_q;
  assign evt_data    = fifoMem_q[rdPtr_q];
  assign evt_valid   = (count_q != '0);
  assign overflow    = overflow_q;
  assign rd_error    = rdError_q;

endmodule

// File: tb/tb_key_poll_master.sv
// Directed self-checking bench for key_poll_master: a latency-1 PIO slave model
// with programmable waitrequest stalls and a switch to withhold readdatavalid.
module tb_key_poll_master;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [1:0]  avmAddress;
  logic        avmRead;
  logic        avmWaitrequest;
  logic [31:0] rdData = 32'h0;
  logic        rdValid = 1'b0;
  logic [3:0]  keyState;
  logic [2:0]  evtData;
  logic        evtValid;
  logic        evtReady = 1'b0;
  logic        overflowFlag;
  logic        rdErrorFlag;
  logic        errClr = 1'b0;

  logic [3:0]  keyPins = 4'hF;
  logic        respond = 1'b1;
  int          stallTarget = 0;
  int          readCycles = 0;

  int          assertCount = 0;
  int          failCount = 0;

  key_poll_master #(
    .POLL_CYCLES(16),
    .DEBOUNCE_SAMPLES(4),
    .KEY_ACTIVE_LOW(1'b1),
    .RD_TIMEOUT(15),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .reset_n(resetN),
    .avm_address(avmAddress),
    .avm_read(avmRead),
    .avm_waitrequest(avmWaitrequest),
    .avm_readdata(rdData),
    .avm_readdatavalid(rdValid),
    .key_state(keyState),
    .evt_data(evtData),
    .evt_valid(evtValid),
    .evt_ready(evtReady),
    .overflow(overflowFlag),
    .rd_error(rdErrorFlag),
    .err_clr(errClr)
  );

  // 10 time-unit clock period.
  always #5 clk = ~clk;

  // Slave stalls the first stallTarget cycles of each read request.
  assign avmWaitrequest = avmRead && (readCycles < stallTarget);

  // Slave model: counts consecutive request cycles and answers an accepted read one cycle later.
  always @(posedge clk) begin
    if (avmRead) readCycles <= readCycles + 1;
    else         readCycles <= 0;
    rdValid <= avmRead && !avmWaitrequest && respond;
    rdData  <= {28'h0, keyPins};
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitReadHigh(input string tag, output int cycles);
    cycles = 0;
    while (avmRead !== 1'b1 && cycles < 64) begin
      @(negedge clk);
      cycles++;
    end
    if (avmRead !== 1'b1) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic waitReadLow(input string tag, output int cycles);
    cycles = 0;
    while (avmRead !== 1'b0 && cycles < 64) begin
      @(negedge clk);
      cycles++;
    end
    if (avmRead !== 1'b0) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic pollOnce(input int settle);
    int c;
    waitReadHigh("pollStart", c);
    waitReadLow("pollEnd", c);
    repeat (settle) @(negedge clk);
  endtask

  task automatic pollN(input int n);
    repeat (n) pollOnce(8);
  endtask

  task automatic popCheck(input string tag, input logic [2:0] expected);
    checkOutput({tag, "_valid"}, {31'h0, evtValid}, 32'd1);
    checkOutput({tag, "_data"}, {29'h0, evtData}, {29'h0, expected});
    evtReady = 1'b1;
    @(negedge clk);
    evtReady = 1'b0;
  endtask

  task automatic pulseErrClr();
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
  endtask

  task automatic applyStimulus();
    int hi;
    int lo;
    logic [2:0] expOrder [8];

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_read", {31'h0, avmRead}, 32'd0);
    checkOutput("rst_keyState", {28'h0, keyState}, 32'd0);
    checkOutput("rst_evtValid", {31'h0, evtValid}, 32'd0);
    checkOutput("rst_overflow", {31'h0, overflowFlag}, 32'd0);
    checkOutput("rst_rdError", {31'h0, rdErrorFlag}, 32'd0);
    resetN = 1'b1;

    // Poll cadence: one-cycle read pulse every 16 cycles at address 0.
    waitReadHigh("cad1", lo);
    checkOutput("cad_address", {30'h0, avmAddress}, 32'd0);
    waitReadLow("cad1", hi);
    checkOutput("cad_readWidth", hi, 32'd1);
    waitReadHigh("cad2", lo);
    checkOutput("cad_period", hi + lo, 32'd16);
    waitReadLow("cad2", hi);
    repeat (8) @(negedge clk);
    checkOutput("cad_keyState", {28'h0, keyState}, 32'd0);
    checkOutput("cad_evtValid", {31'h0, evtValid}, 32'd0);

    // Key 0 pressed: accepted on the 4th sample.
    keyPins = 4'b1110;
    pollN(3);
    checkOutput("k0_after3", {28'h0, keyState}, 32'd0);
    checkOutput("k0_noEvt3", {31'h0, evtValid}, 32'd0);
    pollOnce(8);
    checkOutput("k0_after4", {28'h0, keyState}, 32'd1);
    popCheck("k0_press", 3'b100);
    checkOutput("k0_single", {31'h0, evtValid}, 32'd0);
    keyPins = 4'b1111;
    pollN(4);
    checkOutput("k0_release", {28'h0, keyState}, 32'd0);
    popCheck("k0_relEvt", 3'b000);

    // Key 1 bounces for 10 polls, then settles pressed.
    for (int k = 0; k < 10; k++) begin
      keyPins = (k % 2 == 0) ? 4'b1101 : 4'b1111;
      pollOnce(8);
    end
    checkOutput("k1_bounceState", {28'h0, keyState}, 32'd0);
    checkOutput("k1_bounceEvt", {31'h0, evtValid}, 32'd0);
    keyPins = 4'b1101;
    pollN(3);
    checkOutput("k1_after3", {28'h0, keyState}, 32'd0);
    pollOnce(8);
    checkOutput("k1_after4", {28'h0, keyState}, 32'd2);
    popCheck("k1_press", 3'b101);
    checkOutput("k1_single", {31'h0, evtValid}, 32'd0);
    keyPins = 4'b1111;
    pollN(4);
    popCheck("k1_rel", 3'b001);

    // All four keys pressed together: events in index order.
    keyPins = 4'b0000;
    pollN(4);
    checkOutput("all_keyState", {28'h0, keyState}, 32'hF);
    popCheck("all_0", 3'b100);
    popCheck("all_1", 3'b101);
    popCheck("all_2", 3'b110);
    popCheck("all_3", 3'b111);
    checkOutput("all_empty", {31'h0, evtValid}, 32'd0);

    // Overflow: 12 edges into an 8-deep FIFO with no consumer.
    keyPins = 4'b1111;
    pollN(4);
    keyPins = 4'b0000;
    pollN(4);
    checkOutput("ovf_fullNoFlag", {31'h0, overflowFlag}, 32'd0);
    keyPins = 4'b1111;
    pollN(4);
    checkOutput("ovf_set", {31'h0, overflowFlag}, 32'd1);
    expOrder = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    for (int i = 0; i < 8; i++) popCheck($sformatf("ovf_pop%0d", i), expOrder[i]);
    checkOutput("ovf_drained", {31'h0, evtValid}, 32'd0);
    checkOutput("ovf_sticky", {31'h0, overflowFlag}, 32'd1);
    pulseErrClr();
    checkOutput("ovf_cleared", {31'h0, overflowFlag}, 32'd0);

    // Waitrequest held 5 cycles stretches the read to 6 cycles.
    stallTarget = 5;
    waitReadHigh("stall", lo);
    waitReadLow("stall", hi);
    checkOutput("stall_readWidth", hi, 32'd6);
    stallTarget = 0;
    repeat (8) @(negedge clk);

    // No readdatavalid: rd_error after exactly 15 WAIT cycles, then polling resumes.
    respond = 1'b0;
    pollOnce(0);
    repeat (14) @(negedge clk);
    checkOutput("to_before", {31'h0, rdErrorFlag}, 32'd0);
    @(negedge clk);
    checkOutput("to_set", {31'h0, rdErrorFlag}, 32'd1);
    respond = 1'b1;
    waitReadHigh("to_repoll", lo);
    checkOutput("to_repollRead", {31'h0, avmRead}, 32'd1);
    waitReadLow("to_repoll", hi);
    repeat (8) @(negedge clk);
    checkOutput("to_sticky", {31'h0, rdErrorFlag}, 32'd1);
    pulseErrClr();
    checkOutput("to_cleared", {31'h0, rdErrorFlag}, 32'd0);

    // Reset during WAIT with a queued event and a pressed key.
    keyPins = 4'b1110;
    pollN(4);
    checkOutput("rw_preKey", {28'h0, keyState}, 32'd1);
    checkOutput("rw_preEvt", {31'h0, evtValid}, 32'd1);
    respond = 1'b0;
    pollOnce(0);
    resetN = 1'b0;
    @(negedge clk);
    checkOutput("rw_read", {31'h0, avmRead}, 32'd0);
    checkOutput("rw_keyState", {28'h0, keyState}, 32'd0);
    checkOutput("rw_evtValid", {31'h0, evtValid}, 32'd0);
    checkOutput("rw_rdError", {31'h0, rdErrorFlag}, 32'd0);
    resetN = 1'b1;

    // Reset during a stalled request drops avm_read on the next edge.
    respond = 1'b1;
    stallTarget = 1000;
    waitReadHigh("rr", lo);
    resetN = 1'b0;
    @(negedge clk);
    checkOutput("rr_read", {31'h0, avmRead}, 32'd0);
    resetN = 1'b1;
    stallTarget = 0;
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
